// File: rtl/config_stream_if.sv
// Host-side command/payload handshakes and the config bus outputs of the
// transmitter, bundled so the host and the transmitter share one port.
interface config_stream_if;
  logic       trace_req;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_id;
  logic [7:0] cmd_len;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       err;

  modport master (
    output trace_req, cmd_valid, cmd_id, cmd_len, byte_valid, byte_data,
    input  cmd_ready, byte_ready, tracing, configId, configData, busy, err
  );

  modport slave (
    input  trace_req, cmd_valid, cmd_id, cmd_len, byte_valid, byte_data,
    output cmd_ready, byte_ready, tracing, configId, configData, busy, err
  );
endinterface

// File: rtl/config_stream_transmitter.sv
// Buffers one host-written config packet, then replays it gap-free on the
// byte-serial config bus with tracing held off and idle IDs around it.
module config_stream_transmitter #(
  parameter int         MAX_PKT_BYTES  = 48,
  parameter logic [7:0] IDLE_CONFIG_ID = 8'hFF,
  parameter int         DRAIN_CYCLES   = 4,
  parameter int         GAP_CYCLES     = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  config_stream_if.slave bus
);

  localparam int CW     = $clog2(MAX_PKT_BYTES + 1);
  localparam int PH_MAX = (DRAIN_CYCLES > GAP_CYCLES) ? DRAIN_CYCLES : GAP_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, SEND, GAP} state_t;

  state_t          state, state_d;
  logic [7:0]      mem [MAX_PKT_BYTES];
  logic [7:0]      id_q;
  logic [CW-1:0]   len_q, wr_ptr, rd_ptr, rd_idx;
  logic [PW-1:0]   ph_cnt;

  logic            tracing_q, busy_q, err_q, cmd_ready_q, byte_ready_q;
  logic [7:0]      config_id_q, config_data_q;
  logic            tracing_d, busy_d, err_d, cmd_ready_d, byte_ready_d;
  logic [7:0]      config_id_d, config_data_d;

  logic cmd_acc, cmd_bad, byte_acc, last_byte;

  assign cmd_acc   = (state == IDLE) && bus.cmd_valid && cmd_ready_q;
  assign cmd_bad   = (bus.cmd_len == 8'd0) || (bus.cmd_len > 8'(MAX_PKT_BYTES)) ||
                     (bus.cmd_id == IDLE_CONFIG_ID);
  assign byte_acc  = (state == LOAD) && bus.byte_valid && byte_ready_q;
  assign last_byte = (wr_ptr == len_q - CW'(1));
  // The first SEND byte is fetched while still in DRAIN.
  assign rd_idx    = (state == DRAIN) ? '0 : rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tracing_q     <= 1'b0;
      config_id_q   <= IDLE_CONFIG_ID;
      config_data_q <= 8'd0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      cmd_ready_q   <= 1'b1;
      byte_ready_q  <= 1'b0;
    end else begin
      state         <= state_d;
      tracing_q     <= tracing_d;
      config_id_q   <= config_id_d;
      config_data_q <= config_data_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      cmd_ready_q   <= cmd_ready_d;
      byte_ready_q  <= byte_ready_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_acc && !cmd_bad) state_d = LOAD;
      LOAD:    if (byte_acc && last_byte) state_d = DRAIN;
      DRAIN:   if (ph_cnt == PW'(DRAIN_CYCLES - 1)) state_d = SEND;
      SEND:    if (rd_ptr == len_q) state_d = GAP;
      GAP:     if (ph_cnt == PW'(GAP_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    tracing_d     = 1'b0;
    config_id_d   = IDLE_CONFIG_ID;
    config_data_d = 8'd0;
    busy_d        = 1'b1;
    err_d         = 1'b0;
    cmd_ready_d   = 1'b0;
    byte_ready_d  = 1'b0;
    case (state_d)
      IDLE: begin
        tracing_d   = bus.trace_req;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        err_d       = cmd_acc && cmd_bad;
      end
      LOAD: begin
        tracing_d    = bus.trace_req;
        byte_ready_d = 1'b1;
      end
      SEND: begin
        config_id_d   = id_q;
        config_data_d = mem[rd_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cmd_acc) begin
      id_q   <= bus.cmd_id;
      len_q  <= bus.cmd_len[CW-1:0];
      wr_ptr <= '0;
    end
    if (byte_acc) begin
      mem[wr_ptr] <= bus.byte_data;
      wr_ptr      <= wr_ptr + CW'(1);
    end
    ph_cnt <= (state != state_d) ? '0 : ph_cnt + PW'(1);
    if (state == DRAIN)
      rd_ptr <= CW'(1);
    else if (state == SEND)
      rd_ptr <= rd_ptr + CW'(1);
  end

  assign bus.tracing    = tracing_q;
  assign bus.configId   = config_id_q;
  assign bus.configData = config_data_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.byte_ready = byte_ready_q;

endmodule

// File: tb/tb_config_stream_transmitter.sv
// Directed bench for config_stream_transmitter: nominal, bubbly, rejected,
// maximum-length, back-to-back and mid-SEND reset packets.
module tb_config_stream_transmitter;

  localparam int DRAIN = 4;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  logic [7:0] pkt [48];

  config_stream_if bus ();

  config_stream_transmitter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] id, input logic [7:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_id    = id;
    bus.cmd_len   = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] d);
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  // Entered in the first DRAIN cycle; leaves in the first IDLE cycle.
  task automatic expect_packet(input logic [7:0] id, input int n);
    for (int i = 0; i < DRAIN; i++) begin
      if (i > 0) tick();
      check("drain_id", bus.configId, 8'hFF);
      check("drain_tracing", {7'd0, bus.tracing}, 8'd0);
    end
    for (int i = 0; i < n; i++) begin
      tick();
      check("send_id", bus.configId, id);
      check("send_data", bus.configData, pkt[i]);
      check("send_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
    end
    tick();
    check("gap_id", bus.configId, 8'hFF);
    check("gap_data", bus.configData, 8'd0);
    check("gap_busy", {7'd0, bus.busy}, 8'd1);
    tick();
    check("idle_busy", {7'd0, bus.busy}, 8'd0);
    check("idle_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    check("idle_tracing", {7'd0, bus.tracing}, 8'd1);
  endtask

  task automatic expect_reject(input string tag);
    check({tag, "_err"}, {7'd0, bus.err}, 8'd1);
    check({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
    check({tag, "_id"}, bus.configId, 8'hFF);
    check({tag, "_cmd_ready"}, {7'd0, bus.cmd_ready}, 8'd1);
    tick();
    check({tag, "_err_pulse"}, {7'd0, bus.err}, 8'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n        = 1'b0;
    bus.trace_req  = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_id     = 8'd0;
    bus.cmd_len    = 8'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    tick();
    tick();
    check("rst_tracing", {7'd0, bus.tracing}, 8'd0);
    check("rst_id", bus.configId, 8'hFF);
    check("rst_data", bus.configData, 8'd0);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    check("rst_err", {7'd0, bus.err}, 8'd0);
    check("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    check("rst_byte_ready", {7'd0, bus.byte_ready}, 8'd0);
    reset_n = 1'b1;
    bus.trace_req = 1'b1;
    tick();
    check("idle_trace_follow", {7'd0, bus.tracing}, 8'd1);

    // Nominal packet
    pkt[0] = 8'hA1; pkt[1] = 8'hB2; pkt[2] = 8'hC3;
    send_cmd(8'h02, 8'd3);
    check("nom_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
    check("nom_busy", {7'd0, bus.busy}, 8'd1);
    check("nom_byte_ready", {7'd0, bus.byte_ready}, 8'd1);
    check("nom_load_tracing", {7'd0, bus.tracing}, 8'd1);
    load_byte(8'hA1);
    load_byte(8'hB2);
    check("nom_mid_tracing", {7'd0, bus.tracing}, 8'd1);
    load_byte(8'hC3);
    check("nom_byte_ready_off", {7'd0, bus.byte_ready}, 8'd0);
    expect_packet(8'h02, 3);

    // Bubbly load
    pkt[0] = 8'h10; pkt[1] = 8'h20; pkt[2] = 8'h30; pkt[3] = 8'h40;
    send_cmd(8'h05, 8'd4);
    for (int i = 0; i < 3; i++) begin
      load_byte(pkt[i]);
      tick();
      check("bub_byte_ready", {7'd0, bus.byte_ready}, 8'd1);
    end
    load_byte(pkt[3]);
    expect_packet(8'h05, 4);

    // Rejections
    send_cmd(8'h07, 8'd0);
    expect_reject("rej_len0");
    send_cmd(8'h07, 8'd49);
    expect_reject("rej_len49");
    send_cmd(8'hFF, 8'd1);
    expect_reject("rej_idff");

    // Max packet
    for (int i = 0; i < 48; i++) pkt[i] = 8'(i);
    send_cmd(8'h09, 8'd48);
    for (int i = 0; i < 48; i++) begin
      load_byte(pkt[i]);
      if (i < 47) check("max_load_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
    end
    expect_packet(8'h09, 48);

    // Back-to-back to the same id; next command and a stray byte held early
    pkt[0] = 8'h11;
    send_cmd(8'h03, 8'd1);
    load_byte(8'h11);
    bus.cmd_valid  = 1'b1;
    bus.cmd_id     = 8'h03;
    bus.cmd_len    = 8'd1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    expect_packet(8'h03, 1);
    tick();
    bus.cmd_valid = 1'b0;
    check("b2b_accept", {7'd0, bus.cmd_ready}, 8'd0);
    check("b2b_byte_ready", {7'd0, bus.byte_ready}, 8'd1);
    bus.byte_data = 8'h22;
    tick();
    bus.byte_valid = 1'b0;
    pkt[0] = 8'h22;
    expect_packet(8'h03, 1);

    // Reset during the second byte of SEND
    pkt[0] = 8'h51; pkt[1] = 8'h52; pkt[2] = 8'h53; pkt[3] = 8'h54;
    send_cmd(8'h04, 8'd4);
    for (int i = 0; i < 4; i++) load_byte(pkt[i]);
    for (int i = 0; i < DRAIN; i++) tick();
    check("rs_byte0", bus.configData, 8'h51);
    tick();
    check("rs_byte1", bus.configData, 8'h52);
    reset_n = 1'b0;
    #2;
    check("rs_id", bus.configId, 8'hFF);
    check("rs_tracing", {7'd0, bus.tracing}, 8'd0);
    check("rs_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    check("rs_data", bus.configData, 8'd0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rs_no_replay", bus.configId, 8'hFF);
    end
    pkt[0] = 8'h77;
    send_cmd(8'h06, 8'd1);
    check("rs_new_busy", {7'd0, bus.busy}, 8'd1);
    load_byte(8'h77);
    expect_packet(8'h06, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/config_stream_transmitter.md
Name: config_stream_transmitter

Overview:
Transmitter end of the byte-serial firmware configuration bus (configId/configData plus tracing) consumed by the vector pipeline blocks. A host writes a command (target config ID, byte count) and then the payload bytes into an internal packet buffer. Once the whole packet is buffered, the block stops tracing, drains the pipeline, and replays the packet gap-free, one byte per cycle. It then drives an idle ID so each receiver's byte counter resets before the next packet. The block sits between the host/debug controller and the config bus fan-out.

Parameters:
MAX_PKT_BYTES, 48, largest payload per packet (6 firmware tables x 8 chains); buffer depth.
IDLE_CONFIG_ID, 255, configId value driven whenever no byte is being sent; never a valid target.
DRAIN_CYCLES, 4, cycles tracing is held low before the first byte (≥1).
GAP_CYCLES, 1, idle-ID cycles after the last byte (≥1).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
trace_req  in  1  host requests tracing when not configuring
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_id  in  8  target PERSONAL_CONFIG_ID
cmd_len  in  8  payload byte count
byte_valid  in  1  payload byte offered
byte_ready  out  1  payload byte accepted when byte_valid & byte_ready
byte_data  in  8  payload byte
tracing  out  1  tracing enable to pipeline
configId  out  8  config bus target ID
configData  out  8  config bus data byte
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse: command rejected

Behaviour:
- All outputs are registered. Reset values: tracing=0, configId=IDLE_CONFIG_ID, configData=0, busy=0, err=0, cmd_ready=1, byte_ready=0. FSM resets to IDLE. Counters, pointers and buffer contents are don't-care.
- States: IDLE, LOAD, DRAIN, SEND, GAP.
- IDLE:
  - cmd_ready=1; tracing follows trace_req with 1-cycle lag; configId=IDLE_CONFIG_ID.
  - On command accept, latch id and len.
  - If cmd_len==0, cmd_len>MAX_PKT_BYTES or cmd_id==IDLE_CONFIG_ID: err=1 next cycle, stay IDLE, command discarded.
  - Otherwise go to LOAD; cmd_ready=0 next cycle.
- LOAD:
  - byte_ready=1; each accepted byte is written to buf[wr_ptr], then wr_ptr increments.
  - Input bubbles (byte_valid=0) are allowed and simply wait.
  - The edge that accepts byte number len moves to DRAIN; byte_ready=0 from that edge.
  - tracing still follows trace_req during LOAD.
- DRAIN:
  - tracing=0, configId=IDLE_CONFIG_ID for exactly DRAIN_CYCLES cycles, then SEND.
- SEND:
  - For len consecutive cycles: configId=latched id, configData=buf[rd_ptr], rd_ptr from 0..len-1. No bubbles are permitted; receivers count every cycle.
  - tracing=0. After the last byte, go to GAP.
- GAP:
  - configId=IDLE_CONFIG_ID, configData=0, tracing=0 for GAP_CYCLES cycles, then IDLE.
- Back-to-back commands: the next command can only be accepted in IDLE, so every packet is separated by ≥GAP_CYCLES idle-ID cycles. This applies even for the same target.
- busy=1 from the cycle after a valid command accept until IDLE is re-entered.
- configData=0 whenever configId=IDLE_CONFIG_ID.
- Counter widths: $clog2(MAX_PKT_BYTES+1). Pointers never wrap within a packet, since len≤MAX_PKT_BYTES.
- Simultaneous cmd_valid and byte_valid in IDLE: only the command is taken.
- Reset asserted mid-operation (any state): outputs go to reset values immediately (asynchronously) and the packet is abandoned. No partial replay occurs after release.

Test Plan:
- Nominal packet, DRAIN=4, GAP=1, trace_req=1: cmd id=2 len=3, then bytes A1,B2,C3. Required response:
  - tracing falls the edge after C3 is accepted.
  - 4 cycles of configId=FF.
  - Then 3 consecutive cycles (02,A1),(02,B2),(02,C3).
  - 1 cycle of FF, then IDLE, with tracing=1 one cycle later.
- Bubbly load: bytes 10,20,30,40 for id=5 with byte_valid toggling every other cycle -> SEND still shows 4 contiguous cycles (05,10),(05,20),(05,30),(05,40).
- Rejections:
  - len=0 -> err=1 for one cycle, busy stays 0, configId stays FF.
  - len=49 -> same response.
  - id=FF, len=1 -> same response.
- Max packet: len=48 with bytes 0..47 -> 48 contiguous SEND cycles with data 00..2F in order; cmd_ready=0 throughout.
- Back-to-back to the same id=3, packets (11) then (22) -> at least one FF cycle between (03,11) and (03,22), so the receiver's counter restarts at 0.
- Reset mid-SEND: assert reset_n=0 on the 2nd byte of a 4-byte packet -> configId=FF, tracing=0, cmd_ready=1 immediately. After release, no remaining bytes appear and a new command is accepted normally.
